// File: rtl/systolic_pkg.sv
// Shared defaults and FSM encoding for the systolic array drain path.
package systolic_pkg;

  localparam int DEF_N_COLS     = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } collect_state_t;

endpackage

// File: rtl/psum_row_fifo.sv
// First-word-fall-through FIFO holding aligned partial-sum rows.
module psum_row_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // The extra MSB on each pointer separates a full FIFO from an empty one.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Head is forced to zero when empty so the row output is clean after reset.
  assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/psum_collector.sv
// Deskews the systolic array's bottom-edge outputs into whole rows and
// buffers a fixed-length job of rows for a ready/valid consumer.
module psum_collector
  import systolic_pkg::*;
#(
  parameter int N_COLS     = DEF_N_COLS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               num_rows,
  input  logic [N_COLS-1:0]        col_valid,
  input  logic [N_COLS*DATA_W-1:0] col_psum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_COLS*DATA_W-1:0] out_row,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     skew_err
);

  logic [N_COLS-1:0]        dly_valid;
  logic [N_COLS*DATA_W-1:0] dly_data;

  // Column gi waits N_COLS-1-gi cycles so all columns of a row line up.
  genvar gi;
  generate
    for (gi = 0; gi < N_COLS; gi++) begin : g_col
      localparam int STAGES = N_COLS - 1 - gi;
      if (STAGES == 0) begin : g_direct
        assign dly_valid[gi]                 = col_valid[gi];
        assign dly_data[gi*DATA_W +: DATA_W] = col_psum[gi*DATA_W +: DATA_W];
      end else begin : g_pipe
        logic [STAGES-1:0] v_reg;
        logic [DATA_W-1:0] d_reg [STAGES];
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            v_reg <= '0;
            for (int k = 0; k < STAGES; k++) d_reg[k] <= '0;
          end else begin
            v_reg[0] <= col_valid[gi];
            d_reg[0] <= col_psum[gi*DATA_W +: DATA_W];
            for (int k = 1; k < STAGES; k++) begin
              v_reg[k] <= v_reg[k-1];
              d_reg[k] <= d_reg[k-1];
            end
          end
        end
        assign dly_valid[gi]                 = v_reg[STAGES-1];
        assign dly_data[gi*DATA_W +: DATA_W] = d_reg[STAGES-1];
      end
    end
  endgenerate

  collect_state_t state_reg, state_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic           ovf_reg, ovf_next;
  logic           skew_reg, skew_next;

  logic row_all;
  logic row_partial;
  logic row_in;
  logic fifo_empty;
  logic fifo_full;
  logic pop;

  assign row_all     = &dly_valid;
  assign row_partial = (|dly_valid) && !row_all;
  assign row_in      = row_all && (state_reg == COLLECT);
  assign pop         = out_valid && out_ready;

  psum_row_fifo #(
    .WIDTH (N_COLS*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (row_in),
    .push_data (dly_data),
    .pop       (pop),
    .head_data (out_row),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      skew_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      skew_reg  <= skew_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    skew_next  = skew_reg;
    done       = 1'b0;
    if (row_partial) skew_next = 1'b1;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = COLLECT;
          cnt_next   = (num_rows == 4'd0) ? 4'd1 : num_rows;
          ovf_next   = 1'b0;
          skew_next  = 1'b0;
        end
      end
      COLLECT: begin
        // A dropped row still counts, otherwise a stalled consumer would hang the job.
        if (row_all) begin
          cnt_next = cnt_reg - 4'd1;
          if (fifo_full && !pop) ovf_next = 1'b1;
          if (cnt_reg == 4'd1) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = !fifo_empty;
  assign busy      = (state_reg != IDLE);
  assign overflow  = ovf_reg;
  assign skew_err  = skew_reg;

endmodule

// File: tb/tb_psum_collector.sv
// Scenario bench for psum_collector with a queue-based reference model.
module tb_psum_collector;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int RW = N*W;
  localparam int EW = RW + 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    num_rows = '0;
  logic [N-1:0]  col_valid = '0;
  logic [RW-1:0] col_psum = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_row;
  logic          busy, done, overflow, skew_err;

  always #5 clk = ~clk;

  psum_collector #(.N_COLS(N), .DATA_W(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .col_valid(col_valid), .col_psum(col_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .busy(busy), .done(done), .overflow(overflow), .skew_err(skew_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus schedule: per-cycle column valids/data, rows laid out skewed.
  logic [N-1:0]  sv [0:255];
  logic [RW-1:0] sd [0:255];

  task automatic clear_sched();
    for (int i = 0; i < 256; i++) begin
      sv[i] = '0;
      sd[i] = '0;
    end
  endtask

  // Column j of a row starting at cycle c is presented at c+j (one later if late).
  task automatic add_row(input int c, input logic [RW-1:0] row, input int late_col);
    for (int j = 0; j < N; j++) begin
      int t;
      t = c + j + ((j == late_col) ? 1 : 0);
      sv[t][j] = 1'b1;
      sd[t][j*W +: W] = row[j*W +: W];
    end
  endtask

  task automatic drive(input int t, input bit st, input logic [3:0] nr, input bit rdy);
    col_valid = sv[t];
    col_psum  = sd[t];
    start     = st;
    num_rows  = nr;
    out_ready = rdy;
  endtask

  // Reference model: history of presented words, job state, row queue.
  logic [N-1:0]  hv [0:N-2];
  logic [RW-1:0] hd [0:N-2];
  logic [RW-1:0] mq [$];
  int            m_state = 0;
  int            m_left = 0;
  bit            m_ovf = 0;
  bit            m_skew = 0;
  bit            a_all, a_any, a_pop, a_push, a_v;
  logic [RW-1:0] a_row;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_state = 0;
      m_left  = 0;
      m_ovf   = 0;
      m_skew  = 0;
      for (int k = 0; k < N-1; k++) begin
        hv[k] = '0;
        hd[k] = '0;
      end
    end else begin
      a_all = 1; a_any = 0; a_push = 0; a_row = '0;
      for (int j = 0; j < N; j++) begin
        if (j == N-1) begin
          a_v = col_valid[j];
          a_row[j*W +: W] = col_psum[j*W +: W];
        end else begin
          a_v = hv[N-2-j][j];
          a_row[j*W +: W] = hd[N-2-j][j*W +: W];
        end
        a_all = a_all & a_v;
        a_any = a_any | a_v;
      end
      a_pop = (mq.size() > 0) && out_ready;
      if (a_any && !a_all) m_skew = 1;
      if (m_state == 0) begin
        if (start) begin
          m_state = 1;
          m_left  = (num_rows == 0) ? 1 : int'(num_rows);
          m_ovf   = 0;
          m_skew  = 0;
        end
      end else if (m_state == 1) begin
        if (a_all) begin
          if (mq.size() == D && !a_pop) m_ovf = 1;
          else a_push = 1;
          m_left--;
          if (m_left == 0) m_state = 2;
        end
      end else if (mq.size() == 0) begin
        m_state = 0;
      end
      if (a_pop) void'(mq.pop_front());
      if (a_push) mq.push_back(a_row);
      for (int k = N-2; k > 0; k--) begin
        hv[k] = hv[k-1];
        hd[k] = hd[k-1];
      end
      hv[0] = col_valid;
      hd[0] = col_psum;
    end
  end

  function automatic logic [EW-1:0] model_exp();
    logic [RW-1:0] head;
    bit            mv, mb, md;
    head = (mq.size() > 0) ? mq[0] : '0;
    mv = (mq.size() > 0);
    mb = (m_state != 0);
    md = (m_state == 2) && (mq.size() == 0);
    return {mv, mb, md, m_ovf, m_skew, head};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, done, overflow, skew_err} !== 5'b0 || out_row !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v%b b%b d%b o%b s%b row=%h, want all 0",
               out_valid, busy, done, overflow, skew_err, out_row);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_row();
    int dones = 0;
    clear_sched();
    add_row(1, 32'h807FFD05, -1);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy, done, overflow, skew_err, out_row} !== model_exp()) begin
        n_bad++;
        $display("FAIL single t=%0d: got %h want %h", t,
                 {out_valid, busy, done, overflow, skew_err, out_row}, model_exp());
      end
      if (t == 5) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_row !== 32'h807FFD05) begin
          n_bad++;
          $display("FAIL single_latency: got v=%b row=%h want v=1 row=807ffd05", out_valid, out_row);
        end
      end
      if (done === 1'b1) dones++;
      drive(t, t == 0, 4'd1, 1'b1);
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL single_done: got %0d pulses want 1", dones);
    end
  endtask

  task automatic test_overflow();
    logic [RW-1:0] rows [6];
    logic [RW-1:0] got [$];
    int dones = 0;
    clear_sched();
    for (int r = 0; r < 6; r++) begin
      rows[r] = $urandom();
      add_row(1 + r, rows[r], -1);
    end
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy, done, overflow, skew_err, out_row} !== model_exp()) begin
        n_bad++;
        $display("FAIL overflow t=%0d: got %h want %h", t,
                 {out_valid, busy, done, overflow, skew_err, out_row}, model_exp());
      end
      if (t == 14) begin
        n_cmp++;
        if (overflow !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL overflow_flag: got o%b b%b v%b want 1 1 1", overflow, busy, out_valid);
        end
      end
      if (done === 1'b1) dones++;
      drive(t, t == 0, 4'd6, t >= 14);
      if (out_valid === 1'b1 && out_ready) got.push_back(out_row);
    end
    n_cmp++;
    if (got.size() != 4 || dones != 1) begin
      n_bad++;
      $display("FAIL overflow_count: got %0d pops %0d done, want 4 pops 1 done", got.size(), dones);
    end
    for (int r = 0; r < 4 && r < got.size(); r++) begin
      n_cmp++;
      if (got[r] !== rows[r]) begin
        n_bad++;
        $display("FAIL overflow_order r=%0d: got %h want %h", r, got[r], rows[r]);
      end
    end
  endtask

  task automatic test_full_pop();
    logic [RW-1:0] rows [5];
    logic [RW-1:0] got [$];
    clear_sched();
    for (int r = 0; r < 5; r++) begin
      rows[r] = $urandom();
      add_row((r < 4) ? 1 + r : 8, rows[r], -1);
    end
    for (int t = 0; t < 26; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy, done, overflow, skew_err, out_row} !== model_exp()) begin
        n_bad++;
        $display("FAIL full_pop t=%0d: got %h want %h", t,
                 {out_valid, busy, done, overflow, skew_err, out_row}, model_exp());
      end
      drive(t, t == 0, 4'd5, t >= 11);
      if (out_valid === 1'b1 && out_ready) got.push_back(out_row);
    end
    n_cmp++;
    if (overflow !== 1'b0 || got.size() != 5) begin
      n_bad++;
      $display("FAIL full_pop_ovf: got overflow=%b pops=%0d want 0 and 5", overflow, got.size());
    end
    for (int r = 0; r < 5 && r < got.size(); r++) begin
      n_cmp++;
      if (got[r] !== rows[r]) begin
        n_bad++;
        $display("FAIL full_pop_order r=%0d: got %h want %h", r, got[r], rows[r]);
      end
    end
  endtask

  task automatic test_skew();
    int dones = 0;
    clear_sched();
    add_row(1, $urandom(), 2);
    add_row(10, $urandom(), -1);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy, done, overflow, skew_err, out_row} !== model_exp()) begin
        n_bad++;
        $display("FAIL skew t=%0d: got %h want %h", t,
                 {out_valid, busy, done, overflow, skew_err, out_row}, model_exp());
      end
      if (t == 8) begin
        n_cmp++;
        if (skew_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL skew_flag: got s%b v%b b%b want 1 0 1", skew_err, out_valid, busy);
        end
      end
      if (done === 1'b1) dones++;
      drive(t, t == 0, 4'd1, 1'b1);
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL skew_done: got %0d pulses want 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int pops = 0;
    clear_sched();
    add_row(1, $urandom(), -1);
    add_row(2, $urandom(), -1);
    add_row(4, $urandom(), -1);
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      drive(t, t == 0, 4'd4, 1'b0);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_pre: got v%b b%b want 1 1", out_valid, busy);
    end
    clear_sched();
    drive(0, 1'b0, 4'd0, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, busy, done, overflow, skew_err} !== 5'b0 || out_row !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_now: got v%b b%b d%b o%b s%b row=%h want all 0",
               out_valid, busy, done, overflow, skew_err, out_row);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_hold: got d%b b%b want 0 0", done, busy);
    end
    rst = 1'b0;
    add_row(1, $urandom(), -1);
    add_row(2, $urandom(), -1);
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy, done, overflow, skew_err, out_row} !== model_exp()) begin
        n_bad++;
        $display("FAIL reset_mid_after t=%0d: got %h want %h", t,
                 {out_valid, busy, done, overflow, skew_err, out_row}, model_exp());
      end
      if (done === 1'b1) dones++;
      drive(t, t == 0, 4'd2, 1'b1);
      if (out_valid === 1'b1 && out_ready) pops++;
    end
    n_cmp++;
    if (dones != 1 || pops != 2) begin
      n_bad++;
      $display("FAIL reset_mid_job: got %0d done %0d pops want 1 and 2", dones, pops);
    end
  endtask

  task automatic test_idle_rows();
    logic [RW-1:0] rows [2];
    logic [RW-1:0] got [$];
    clear_sched();
    add_row(0, $urandom(), -1);
    add_row(1, $urandom(), -1);
    rows[0] = $urandom();
    rows[1] = $urandom();
    add_row(7, rows[0], -1);
    add_row(8, rows[1], -1);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy, done, overflow, skew_err, out_row} !== model_exp()) begin
        n_bad++;
        $display("FAIL idle_rows t=%0d: got %h want %h", t,
                 {out_valid, busy, done, overflow, skew_err, out_row}, model_exp());
      end
      drive(t, t == 6, 4'd2, 1'b1);
      if (out_valid === 1'b1 && out_ready) got.push_back(out_row);
    end
    n_cmp++;
    if (got.size() != 2 || got[0] !== rows[0] || got[got.size()-1] !== rows[1]) begin
      n_bad++;
      $display("FAIL idle_rows_out: got %0d rows first=%h, want 2 rows %h %h",
               got.size(), (got.size() > 0) ? got[0] : '0, rows[0], rows[1]);
    end
  endtask

  task automatic test_random();
    for (int job = 0; job < 6; job++) begin
      int nr, eff, c, extra_t, t, dones;
      bit finished;
      clear_sched();
      nr  = $urandom_range(0, 15);
      eff = (nr == 0) ? 1 : nr;
      c   = 1;
      for (int r = 0; r < eff; r++) begin
        add_row(c, $urandom(), -1);
        c += $urandom_range(1, 3);
      end
      extra_t  = $urandom_range(2, 5);
      dones    = 0;
      finished = 0;
      t        = 0;
      while (!finished && t < 200) begin
        @(negedge clk);
        n_cmp++;
        if ({out_valid, busy, done, overflow, skew_err, out_row} !== model_exp()) begin
          n_bad++;
          $display("FAIL random j=%0d t=%0d: got %h want %h", job, t,
                   {out_valid, busy, done, overflow, skew_err, out_row}, model_exp());
        end
        if (done === 1'b1) dones++;
        if (t > c + N && m_state == 0 && busy === 1'b0) finished = 1;
        drive(t, (t == 0) || (t == extra_t), 4'(nr), $urandom_range(0, 3) != 0);
        t++;
      end
      n_cmp++;
      if (!finished || dones != 1) begin
        n_bad++;
        $display("FAIL random_end j=%0d: got finished=%0d dones=%0d want 1 1", job, finished, dones);
      end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_row();
    test_overflow();
    test_full_pop();
    test_skew();
    test_reset_mid();
    test_idle_rows();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
